// File: rtl/xilinx_exit_status_uart_pkg.sv
// Shared types and message constants for the exit-status UART reporter.
// Holds the serializer state encoding and the ASCII message builder.
package xilinx_exit_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } exit_uart_state_e;

  localparam int         MSG_LEN  = 15;
  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_X  = 8'h58;
  localparam logic [7:0] CH_I  = 8'h49;
  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    logic [7:0] n8;
    n8 = {4'h0, n};
    return (n < 4'd10) ? (8'h30 + n8) : (8'h37 + n8);
  endfunction

  // "EXIT=" + 8 hex digits (MSB nibble first) + CR LF
  function automatic logic [7:0] msg_byte(input logic [3:0] idx, input logic [31:0] v);
    logic [7:0] b;
    b = CH_LF;
    case (idx)
      4'd0:    b = CH_E;
      4'd1:    b = CH_X;
      4'd2:    b = CH_I;
      4'd3:    b = CH_T;
      4'd4:    b = CH_EQ;
      4'd5:    b = nibble_to_ascii(v[31:28]);
      4'd6:    b = nibble_to_ascii(v[27:24]);
      4'd7:    b = nibble_to_ascii(v[23:20]);
      4'd8:    b = nibble_to_ascii(v[19:16]);
      4'd9:    b = nibble_to_ascii(v[15:12]);
      4'd10:   b = nibble_to_ascii(v[11:8]);
      4'd11:   b = nibble_to_ascii(v[7:4]);
      4'd12:   b = nibble_to_ascii(v[3:0]);
      4'd13:   b = CH_CR;
      default: b = CH_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/xilinx_exit_status_uart_if.sv
// MCU exit handshake in, UART pin and status LEDs out.
// master = MCU/board side, slave = the reporter block.
interface xilinx_exit_status_uart_if #(
  parameter int DATA_W = 32
);
  logic              exit_valid_i;
  logic [DATA_W-1:0] exit_value_i;
  logic              tx_o;
  logic              busy_o;
  logic              done_o;
  logic              pass_led_o;
  logic              fail_led_o;

  modport master (
    output exit_valid_i, exit_value_i,
    input  tx_o, busy_o, done_o, pass_led_o, fail_led_o
  );

  modport slave (
    input  exit_valid_i, exit_value_i,
    output tx_o, busy_o, done_o, pass_led_o, fail_led_o
  );
endinterface

// File: rtl/xilinx_exit_status_uart_tx_byte.sv
// 8N1 serializer: tx_o goes low the cycle after a byte is accepted; 10*CLKS_PER_BIT cycles per byte.
// ready_o is high when idle and on the last stop cycle, so back-to-back bytes leave no idle gap.
module uart_tx_byte
  import xilinx_exit_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 130
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] byte_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  exit_uart_state_e state;
  logic [BW-1:0]    baud;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             baud_wrap;

  assign baud_wrap = (baud == BAUD_LAST);
  assign ready_o   = (state == IDLE) || ((state == STOP) && baud_wrap);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      baud <= ((state == IDLE) || baud_wrap) ? '0 : baud + 1'b1;
      case (state)
        IDLE: begin
          if (valid_i) begin
            state <= START;
            tx_o  <= 1'b0;
            shreg <= byte_i;
          end
        end
        START: begin
          if (baud_wrap) begin
            state   <= DATA;
            bit_idx <= '0;
            tx_o    <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx_o  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_o    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        STOP: begin
          // Chaining straight into the next start bit keeps frames gapless.
          if (baud_wrap) begin
            if (valid_i) begin
              state <= START;
              tx_o  <= 1'b0;
              shreg <= byte_i;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/xilinx_exit_status_uart.sv
// Captures the MCU exit value on a rising exit_valid and streams "EXIT=XXXXXXXX\r\n" out the UART.
// Start bit appears one cycle after capture; triggers while a message is in flight are dropped.
module xilinx_exit_status_uart
  import xilinx_exit_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 130,
  parameter int DATA_W       = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  xilinx_exit_status_uart_if.slave   bus
);

  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] value_q;
  logic [3:0]        char_idx;

  logic       trigger;
  logic       start_msg;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_byte;
  logic       tx_line;

  assign trigger   = bus.exit_valid_i && !valid_q;
  assign start_msg = trigger && !busy_q;

  // The first byte is a constant, so it can be handed over in the capture cycle itself.
  assign tx_valid = start_msg || (busy_q && (char_idx != LAST_IDX));
  assign tx_byte  = start_msg ? CH_E : msg_byte(char_idx + 4'd1, value_q);

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .byte_i  (tx_byte),
    .valid_i (tx_valid),
    .ready_o (tx_ready),
    .tx_o    (tx_line)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      value_q  <= '0;
      char_idx <= '0;
    end else begin
      valid_q <= bus.exit_valid_i;
      if (start_msg) begin
        value_q  <= bus.exit_value_i;
        char_idx <= '0;
        busy_q   <= 1'b1;
        done_q   <= 1'b0;
      end else if (busy_q && tx_ready) begin
        // tx_ready while busy marks the last stop cycle of the current byte.
        if (char_idx == LAST_IDX) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          char_idx <= char_idx + 4'd1;
        end
      end
    end
  end

  assign bus.tx_o       = tx_line;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.pass_led_o = done_q && (value_q == '0);
  assign bus.fail_led_o = done_q && (value_q != '0);

endmodule

// File: tb/tb_xilinx_exit_status_uart.sv
// Bench for the exit-status UART: vector table of exit values plus reset and retrigger sequences.
// A mid-bit UART monitor pops expected bytes from a scoreboard queue.
module tb_xilinx_exit_status_uart;

  localparam int CPB   = 4;
  localparam int FRAME = 150 * CPB;

  logic clk_gen = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_gen = ~clk_gen;

  xilinx_exit_status_uart_if #(.DATA_W(32)) bus ();

  xilinx_exit_status_uart #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (32)
  ) dut (
    .clk_i (clk_gen),
    .rst_i (rst),
    .bus   (bus)
  );

  int         n_vec  = 0;
  int         n_bad  = 0;
  bit         mon_en = 1'b1;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [31:0] val;
    bit          exp_pass;
    int          glitch_at;
    logic [31:0] glitch_val;
    int          hold_after;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : uart_mon
    logic [7:0] b;
    logic [7:0] e;
    logic       s0;
    logic       s1;
    forever begin
      @(negedge clk_gen);
      if (!rst && bus.tx_o === 1'b0) begin
        repeat (CPB / 2) @(negedge clk_gen);
        s0 = bus.tx_o;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk_gen);
          b[i] = bus.tx_o;
        end
        repeat (CPB) @(negedge clk_gen);
        s1 = bus.tx_o;
        if (mon_en) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL uart_byte: unexpected byte %h with nothing expected", b);
          end else begin
            e = exp_q.pop_front();
            check("uart_byte", {22'b0, s0, s1, b}, {22'b0, 1'b0, 1'b1, e});
          end
        end
      end
    end
  end

  task automatic push_msg(input logic [31:0] val);
    string      pre = "EXIT=";
    string      hx  = "0123456789ABCDEF";
    logic [3:0] nib;
    for (int i = 0; i < 5; i++) exp_q.push_back(pre[i]);
    for (int k = 0; k < 8; k++) begin
      nib = val[31 - 4*k -: 4];
      exp_q.push_back(hx[nib]);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Called at the negedge of the first busy cycle; returns the busy length.
  task automatic measure_frame(input int glitch_at, input logic [31:0] glitch_val, output int cnt);
    cnt = 1;
    while (bus.busy_o && cnt < 4 * FRAME) begin
      if (cnt == glitch_at) bus.exit_valid_i = 1'b0;
      if (cnt == glitch_at + 1) begin
        bus.exit_value_i = glitch_val;
        bus.exit_valid_i = 1'b1;
      end
      @(negedge clk_gen);
      if (bus.busy_o) cnt++;
    end
  endtask

  task automatic run_msg(input vec_t v);
    int cnt;
    bit saw_busy;
    bus.exit_valid_i = 1'b0;
    repeat (3) @(negedge clk_gen);
    push_msg(v.val);
    bus.exit_value_i = v.val;
    bus.exit_valid_i = 1'b1;
    @(negedge clk_gen);
    check("busy_after_capture", 32'(bus.busy_o), 32'd1);
    check("tx_start_bit", 32'(bus.tx_o), 32'd0);
    check("done_clear_at_capture", 32'(bus.done_o), 32'd0);
    measure_frame(v.glitch_at, v.glitch_val, cnt);
    check("frame_len", 32'(cnt), 32'(FRAME));
    check("done_after", 32'(bus.done_o), 32'd1);
    check("pass_led", 32'(bus.pass_led_o), 32'(v.exp_pass));
    check("fail_led", 32'(bus.fail_led_o), 32'(!v.exp_pass));
    repeat (4) @(negedge clk_gen);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    saw_busy = 1'b0;
    for (int i = 0; i < v.hold_after; i++) begin
      @(negedge clk_gen);
      if (bus.busy_o) saw_busy = 1'b1;
    end
    check("no_retrigger", 32'(saw_busy), 32'd0);
    check("done_sticky", 32'(bus.done_o), 32'd1);
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge clk_gen);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin : stim
    int   cnt;
    vec_t rv;

    //            value          pass  glitch  glitch_val    hold
    vecs[0] = '{32'h0000_0000, 1'b1,  -1,   32'h0,          10};
    vecs[1] = '{32'hDEAD_BEEF, 1'b0,  -1,   32'h0,          10};
    vecs[2] = '{32'h0000_0000, 1'b1, 100,   32'h0000_0001,  50};
    vecs[3] = '{32'h1234_5678, 1'b0,  -1,   32'h0,        1400};
    vecs[4] = '{32'h0000_000A, 1'b0,  -1,   32'h0,          10};
    vecs[5] = '{32'h0000_0000, 1'b1, 599,   32'h0000_0005, 700};
    vecs[6] = '{32'h9ABC_0DEF, 1'b0,  -1,   32'h0,          10};

    bus.exit_valid_i = 1'b0;
    bus.exit_value_i = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk_gen);
    check("rst_tx", 32'(bus.tx_o), 32'd1);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_pass", 32'(bus.pass_led_o), 32'd0);
    check("rst_fail", 32'(bus.fail_led_o), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk_gen);

    for (int i = 0; i < 7; i++) run_msg(vecs[i]);

    // Reset mid-DATA, with exit_valid held high across reset.
    mon_en = 1'b0;
    bus.exit_valid_i = 1'b0;
    repeat (3) @(negedge clk_gen);
    bus.exit_value_i = 32'h0000_0055;
    bus.exit_valid_i = 1'b1;
    @(negedge clk_gen);
    check("rst_test_busy", 32'(bus.busy_o), 32'd1);
    repeat (20) @(negedge clk_gen);
    rst = 1'b1;
    @(negedge clk_gen);
    check("midframe_rst_tx", 32'(bus.tx_o), 32'd1);
    check("midframe_rst_busy", 32'(bus.busy_o), 32'd0);
    check("midframe_rst_done", 32'(bus.done_o), 32'd0);
    rst = 1'b0;
    @(negedge clk_gen);
    check("retrig_busy", 32'(bus.busy_o), 32'd1);
    check("retrig_tx_start", 32'(bus.tx_o), 32'd0);
    measure_frame(-1, 32'h0, cnt);
    check("retrig_frame_len", 32'(cnt), 32'(FRAME));
    check("retrig_fail_led", 32'(bus.fail_led_o), 32'd1);
    repeat (60) @(negedge clk_gen);
    mon_en = 1'b1;

    rv = '{32'hFFFF_FFFF, 1'b0, -1, 32'h0, 10};
    run_msg(rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/xilinx_exit_status_uart.md
Name: xilinx_exit_status_uart

Overview:
Downstream debug stage on the FPGA top level. Consumes the MCU's exit_valid / 32-bit exit_value pair. On each new exit it transmits a fixed ASCII status line over a dedicated board UART TX pin, so a host sees program results without JTAG. It also drives sticky pass/fail LEDs.

Parameters:
CLKS_PER_BIT, 130, clock cycles per UART bit (15 MHz / 115200); legal range >= 2
DATA_W, 32, exit value width; fixed at 32 (message format depends on it)

Ports:
clk_i  input  1  system clock (generated FPGA clock)
rst_i  input  1  reset
exit_valid_i  input  1  MCU exit valid level
exit_value_i  input  32  MCU exit value, sampled on the exit_valid_i rising edge
tx_o  output  1  UART TX, 8N1, LSB first, idle high
busy_o  output  1  high while a message is in flight
done_o  output  1  sticky, high after the last stop bit of a message
pass_led_o  output  1  done_o && captured value == 0
fail_led_o  output  1  done_o && captured value != 0

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset values: tx_o=1, busy_o=0, done_o=0, pass_led_o=0, fail_led_o=0. Captured value=0, edge-detect register=0, FSM=IDLE.
- Edge detect: valid_q registers exit_valid_i. A trigger is exit_valid_i && !valid_q. A level held high triggers once only.
- Capture (trigger in IDLE at clock edge N):
  - the value register loads exit_value_i; char index=0; done_o clears.
  - From cycle N+1: busy_o=1 and FSM=START, so tx_o=0.
- Trigger while busy: ignored. The first exit wins and no queueing is done.
- Message: 15 bytes, "EXIT=" followed by 8 uppercase hex digits, MSB nibble first, then CR (0x0D) and LF (0x0A).
  - Hex digit k (k=0..7) encodes value[31-4k -: 4].
  - Nibble n maps to 0x30+n if n<10, else 0x41+n-10.
- FSM states: IDLE, START, DATA, STOP.
  - START: tx_o=0 for CLKS_PER_BIT cycles.
  - DATA: bits 0..7 of the current byte, each for CLKS_PER_BIT cycles.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. On the last stop cycle, if char index==14, go to IDLE: busy_o=0 and done_o=1 from the next cycle. Otherwise increment the char index and go to START. There is no idle gap between bytes.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps to 0, and the bit advances on the wrap. Bit counter is 3 bits (0..7).
- Frame length: exactly 150*CLKS_PER_BIT cycles from the first tx_o=0 to busy_o falling.
- LEDs: combinational from done_o and the captured value.
- Re-arm: after done_o, exit_valid_i must fall and rise again. That starts a new message and done_o clears at capture.
- Reset mid-frame: on the next edge tx_o=1, busy_o=0, and the FSM returns to IDLE. valid_q=0, so an exit_valid_i still held high retriggers after reset is released.
- Simultaneous trigger with the last stop cycle: the FSM is not yet IDLE, so the trigger is ignored.

Decomposition:
- Shared package xilinx_exit_uart_pkg holds:
  - state enum exit_uart_state_e;
  - MSG_LEN=15;
  - prefix byte constants 0x45 0x58 0x49 0x54 0x3D;
  - CR/LF constants;
  - nibble-to-ASCII function.
- Natural sub-module: uart_tx_byte, an 8N1 serializer with byte_i, valid_i, ready_o and tx_o, parameterised by CLKS_PER_BIT.
  - The top keeps the message sequencer, capture and LEDs.

Test Plan:
- All scenarios use CLKS_PER_BIT=4 and a UART monitor sampling mid-bit.
1. exit_value=0x00000000, exit_valid rising -> bytes 45 58 49 54 3D 30×8 0D 0A. busy_o high for 600 cycles. Then done_o=1, pass_led_o=1, fail_led_o=0.
2. exit_value=0xDEADBEEF -> hex bytes 44 45 41 44 42 45 45 46. fail_led_o=1 after done.
3. Second rising edge with value 0x1 during byte 3 of the first message -> only the first message is sent, and its hex equals the first captured value.
4. rst_i asserted for 1 cycle mid-DATA -> tx_o=1 and busy_o=0 on the next cycle. exit_valid held high after reset releases -> a full new message starts (tx_o=0 one cycle after capture).
5. exit_valid held high for 2000 cycles -> exactly one message. Then exit_valid low, then high again with value 0x0000000A -> done_o clears at capture and "EXIT=0000000A\r\n" is sent.
6. Trigger coincident with the final stop cycle -> ignored. busy_o falls and done_o=1 with no new frame.
